// File: rtl/multi_timer_ip_if.sv
// Configuration, control and status bundle of the multi-channel timer.
// The master side programs the timer; the slave side is the timer itself.
interface multi_timer_ip_if #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8,
    parameter int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [PRESCALE_W-1:0]   prescale_div;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_periodic;
    logic [NUM_CH-1:0]       ch_clear;
    logic                    cfg_wr;
    logic [CH_IDX_W-1:0]     cfg_ch;
    logic [WIDTH-1:0]        cfg_compare;
    logic [NUM_CH-1:0]       irq_ack;
    logic [NUM_CH-1:0]       irq_mask;
    logic [NUM_CH*WIDTH-1:0] ch_value;
    logic [NUM_CH-1:0]       irq_pending;
    logic                    irq_any;

    modport master (
        output prescale_div, ch_enable, ch_periodic, ch_clear,
               cfg_wr, cfg_ch, cfg_compare, irq_ack, irq_mask,
        input  ch_value, irq_pending, irq_any
    );

    modport slave (
        input  prescale_div, ch_enable, ch_periodic, ch_clear,
               cfg_wr, cfg_ch, cfg_compare, irq_ack, irq_mask,
        output ch_value, irq_pending, irq_any
    );
endinterface

// File: rtl/multi_timer_ip.sv
// NUM_CH independent up-counting timer channels sharing one free-running prescaler,
// each with a compare register, one-shot/periodic mode and a sticky pending flag.
module multi_timer_ip #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8,
    parameter int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    multi_timer_ip_if.slave    bus
);

    // IDLE is not stored: a channel is idle whenever its enable is low and
    // resumes in the state held here when the enable returns.
    typedef enum logic {
        ST_RUN,
        ST_EXPIRED
    } ch_state_t;

    logic [PRESCALE_W-1:0] prescaler;
    logic                  tick;
    logic [WIDTH-1:0]      counter [NUM_CH];
    logic [WIDTH-1:0]      compare [NUM_CH];
    ch_state_t             state   [NUM_CH];
    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     running;
    logic [NUM_CH-1:0]     match;

    assign tick = (prescaler == bus.prescale_div);

    // A divisor lowered below the current count lets the prescaler run on to its natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

    always_comb begin
        running = '0;
        match   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            running[i] = bus.ch_enable[i] && (state[i] == ST_RUN);
            match[i]   = running[i] && tick && (counter[i] == compare[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                compare[i] <= '1;
            end
        end else if (bus.cfg_wr && (int'(bus.cfg_ch) < NUM_CH)) begin
            compare[bus.cfg_ch] <= bus.cfg_compare;
        end
    end

    // Clear beats match, and a match beats an acknowledge in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                counter[i] <= '0;
                state[i]   <= ST_RUN;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ch_clear[i]) begin
                    counter[i] <= '0;
                    state[i]   <= ST_RUN;
                    pending[i] <= 1'b0;
                end else if (match[i]) begin
                    pending[i] <= 1'b1;
                    if (bus.ch_periodic[i]) begin
                        counter[i] <= '0;
                    end else begin
                        state[i] <= ST_EXPIRED;
                    end
                end else begin
                    if (running[i] && tick) begin
                        counter[i] <= counter[i] + WIDTH'(1);
                    end
                    if (bus.irq_ack[i]) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_value
        assign bus.ch_value[g*WIDTH +: WIDTH] = counter[g];
    end

    assign bus.irq_pending = pending;
    assign bus.irq_any     = |(pending & bus.irq_mask);

endmodule

// File: tb/tb_multi_timer_ip.sv
// Self-checking bench for multi_timer_ip: a table of stimulus steps with expected
// outputs queued on a scoreboard, plus hand-written async-reset and channel-index sequences.
module tb_multi_timer_ip;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int PW  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_timer_ip_if #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE_W(PW)) bus ();
    multi_timer_ip_if #(.NUM_CH(3),   .WIDTH(W), .PRESCALE_W(PW)) bus3 ();

    multi_timer_ip #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_timer_ip #(.NUM_CH(3), .WIDTH(W), .PRESCALE_W(PW)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        string           name;
        logic [PW-1:0]   div;
        logic [NCH-1:0]  en;
        logic [NCH-1:0]  per;
        logic [NCH-1:0]  clr;
        logic [NCH-1:0]  ack;
        logic [NCH-1:0]  mask;
        logic            wr;
        logic [1:0]      wch;
        logic [W-1:0]    wcmp;
        int              n;
        logic [NCH*W-1:0] e_val;
        logic [NCH-1:0]  e_pend;
        logic            e_any;
    } vec_t;

    typedef struct {
        string            name;
        logic [NCH*W-1:0] val;
        logic [NCH-1:0]   pend;
        logic             any;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add_vec(input string name, input logic [PW-1:0] div,
                           input logic [NCH-1:0] en, input logic [NCH-1:0] per,
                           input logic [NCH-1:0] clr, input logic [NCH-1:0] ack,
                           input logic [NCH-1:0] mask, input logic wr,
                           input logic [1:0] wch, input logic [W-1:0] wcmp, input int n,
                           input logic [NCH*W-1:0] e_val, input logic [NCH-1:0] e_pend,
                           input logic e_any);
        vec_t v;
        v.name = name;  v.div = div;   v.en = en;     v.per = per;
        v.clr = clr;    v.ack = ack;   v.mask = mask; v.wr = wr;
        v.wch = wch;    v.wcmp = wcmp; v.n = n;
        v.e_val = e_val; v.e_pend = e_pend; v.e_any = e_any;
        vecs.push_back(v);
    endtask

    task automatic push_expect(input string name, input logic [NCH*W-1:0] val,
                               input logic [NCH-1:0] pend, input logic any);
        exp_t e;
        e.name = name; e.val = val; e.pend = pend; e.any = any;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.prescale_div = v.div;
        bus.ch_enable    = v.en;
        bus.ch_periodic  = v.per;
        bus.ch_clear     = v.clr;
        bus.irq_ack      = v.ack;
        bus.irq_mask     = v.mask;
        bus.cfg_wr       = v.wr;
        bus.cfg_ch       = v.wch;
        bus.cfg_compare  = v.wcmp;
        push_expect(v.name, v.e_val, v.e_pend, v.e_any);
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.ch_value !== e.val) begin
            errors++;
            $display("[TB] FAIL %s ch_value: got %h, expected %h", e.name, bus.ch_value, e.val);
        end
        checks++;
        if (bus.irq_pending !== e.pend) begin
            errors++;
            $display("[TB] FAIL %s irq_pending: got %b, expected %b", e.name, bus.irq_pending, e.pend);
        end
        checks++;
        if (bus.irq_any !== e.any) begin
            errors++;
            $display("[TB] FAIL %s irq_any: got %b, expected %b", e.name, bus.irq_any, e.any);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // T1: one-shot ch0, compare 5, tick every cycle
        add_vec("t1_cfg",     4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'd5, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t1_count",   4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 5,  16'h0005, 4'b0000, 1'b0);
        add_vec("t1_match",   4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0005, 4'b0001, 1'b0);
        add_vec("t1_ack",     4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0005, 4'b0000, 1'b0);
        add_vec("t1_frozen",  4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 8,  16'h0005, 4'b0000, 1'b0);
        add_vec("t1_clear",   4'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t1_idle",    4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 3,  16'h0000, 4'b0000, 1'b0);
        // T2: periodic ch1, compare 2, divide by 4
        add_vec("t2_cfg",     4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'd2, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t2_wait",    4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 2,  16'h0000, 4'b0000, 1'b0);
        add_vec("t2_step1",   4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0010, 4'b0000, 1'b0);
        add_vec("t2_step2",   4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 4,  16'h0020, 4'b0000, 1'b0);
        add_vec("t2_wrap",    4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 4,  16'h0000, 4'b0010, 1'b0);
        add_vec("t2_ack",     4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t2_run",     4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 10, 16'h0020, 4'b0000, 1'b0);
        add_vec("t2_rematch", 4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0010, 1'b0);
        add_vec("t2_mask",    4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0010, 1'b1);
        add_vec("t2_stop",    4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        // Prescaler sits at 2 with divisor 0: no tick until it wraps past 15
        add_vec("pre_wrap",   4'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 14, 16'h0000, 4'b0000, 1'b0);
        add_vec("pre_tick",   4'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 3,  16'h0300, 4'b0000, 1'b0);
        add_vec("pre_clear",  4'd0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        // T4: compare lowered below the running count on ch3
        add_vec("t4_count",   4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 10, 16'hA000, 4'b0000, 1'b0);
        add_vec("t4_cfg",     4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'd3, 1,  16'hB000, 4'b0000, 1'b0);
        add_vec("t4_top",     4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 4,  16'hF000, 4'b0000, 1'b0);
        add_vec("t4_wrap",    4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 4,  16'h3000, 4'b0000, 1'b0);
        add_vec("t4_match",   4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h3000, 4'b1000, 1'b0);
        add_vec("t4_clear",   4'd0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        // T5: all four channels periodic with compare 2
        add_vec("t5_cfg0",    4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'd2, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t5_cfg2",    4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'd2, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t5_cfg3",    4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'd2, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t5_clear",   4'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b0000, 1'b0);
        add_vec("t5_count",   4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'd0, 2,  16'h2222, 4'b0000, 1'b0);
        add_vec("t5_match",   4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b1111, 1'b1);
        add_vec("t5_ack02",   4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h1111, 4'b1010, 1'b0);
        add_vec("t5_rematch", 4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'd0, 2,  16'h0000, 4'b1111, 1'b1);
        // T3: ack on ch0 and clear on ch1 land on the matching tick
        add_vec("t3_ackall",  4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h1111, 4'b0000, 1'b0);
        add_vec("t3_count",   4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h2222, 4'b0000, 1'b0);
        add_vec("t3_collide", 4'd0, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h0000, 4'b1101, 1'b1);
        add_vec("t6_pre",     4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'd0, 1,  16'h1111, 4'b1101, 1'b1);

        rst = 1'b1;
        bus.prescale_div = '0; bus.ch_enable = '0; bus.ch_periodic = '0; bus.ch_clear = '0;
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_compare = '0; bus.irq_ack = '0; bus.irq_mask = '0;
        bus3.prescale_div = '0; bus3.ch_enable = '0; bus3.ch_periodic = '0; bus3.ch_clear = '0;
        bus3.cfg_wr = 1'b0; bus3.cfg_ch = '0; bus3.cfg_compare = '0; bus3.irq_ack = '0; bus3.irq_mask = '0;
        repeat (2) @(negedge clk);
        push_expect("reset", '0, '0, 1'b0);
        check_output();
        rst = 1'b0;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k]);
            repeat (vecs[k].n) @(negedge clk);
            check_output();
        end

        // T6: asynchronous reset between edges with pending set
        #2;
        rst = 1'b1;
        #1;
        push_expect("t6_async_rst", '0, '0, 1'b0);
        check_output();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_expect("t6_restart", 16'h3333, 4'b0000, 1'b0);
        check_output();

        // Three-channel instance: a write to index 3 must not land anywhere
        bus3.cfg_wr = 1'b1;
        bus3.cfg_ch = 2'd3;
        bus3.cfg_compare = 4'd1;
        @(negedge clk);
        bus3.cfg_ch = 2'd2;
        @(negedge clk);
        bus3.cfg_wr = 1'b0;
        bus3.ch_enable = 3'b111;
        bus3.ch_periodic = 3'b111;
        repeat (2) @(negedge clk);
        checks++;
        if (bus3.ch_value !== 12'h022) begin
            errors++;
            $display("[TB] FAIL idx_ignore ch_value: got %h, expected %h", bus3.ch_value, 12'h022);
        end
        checks++;
        if (bus3.irq_pending !== 3'b100) begin
            errors++;
            $display("[TB] FAIL idx_ignore irq_pending: got %b, expected %b", bus3.irq_pending, 3'b100);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
